// File: rtl/gyruss_sprite_ram_pkg.sv
// Shared types and constants for the Gyruss sprite attribute RAM.
// Holds the copy-engine state encoding and the per-sprite byte layout.
package gyruss_sprite_ram_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW         = 8;

  // Byte offsets inside one 4-byte sprite record.
  localparam logic [1:0] OFS_Y    = 2'd3;
  localparam logic [1:0] OFS_ATTR = 2'd2;
  localparam logic [1:0] OFS_CODE = 2'd1;
  localparam logic [1:0] OFS_X    = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } copy_state_e;

endpackage

// File: rtl/gyruss_dpram.sv
// Simple dual-port RAM: port A read/write, port B read-only.
// Both read ports are registered, return pre-write data and hold while disabled.
module gyruss_dpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  // NOTE: the array has no reset; clearing every word would turn it into flops, and contents must survive reset.
  always_ff @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_en && !a_we) a_rdata_d = mem[a_addr];
    if (b_en)          b_rdata_d = mem[b_addr];
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values, including the memory read above.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/gyruss_sprite_ram.sv
// Double-buffered sprite attribute RAM: CPU writes a shadow bank, and a copy
// engine moves it into the renderer-visible active bank on each VBLANK rise.
module gyruss_sprite_ram
  import gyruss_sprite_ram_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          VCLKx8,
  input  logic          RESET,
  input  logic          VBLK,
  input  logic [AW-1:0] CPAD,
  input  logic [7:0]    CPDI,
  input  logic          CPCS,
  input  logic          CPWR,
  output logic [7:0]    CPDO,
  input  logic [AW-1:0] SPAA,
  output logic [7:0]    SPAD,
  output logic          CPBSY,
  output logic          DIRTY
);

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

  copy_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wadr_q, wadr_d;
  logic          wen_q, wen_d;
  logic          vblk_q, vblk_d;
  logic          dirty_q, dirty_d;

  logic          cpu_wr;
  logic          vblk_rise;
  logic          copy_rd;
  logic          act_we;
  logic [7:0]    copy_data;
  logic [7:0]    act_rd_unused;

  assign cpu_wr    = CPCS & CPWR;
  assign vblk_rise = VBLK & ~vblk_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dirty_d = dirty_q;
    wen_d   = 1'b0;
    wadr_d  = cnt_q;
    vblk_d  = VBLK;
    copy_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vblk_rise && dirty_q) begin
          dirty_d = 1'b0;
          cnt_d   = '0;
          state_d = COPY;
        end
      end
      COPY: begin
        copy_rd = 1'b1;
        wen_d   = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DRAIN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A CPU write in the copy-start cycle must leave DIRTY set.
    if (cpu_wr) dirty_d = 1'b1;
  end

  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wadr_q  <= '0;
      wen_q   <= 1'b0;
      vblk_q  <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wadr_q  <= wadr_d;
      wen_q   <= wen_d;
      vblk_q  <= vblk_d;
      dirty_q <= dirty_d;
    end
  end

  // The pending pipe write is dropped in a reset cycle, leaving a partial copy.
  assign act_we = wen_q & ~RESET;

  gyruss_dpram #(.AW(AW), .DW(8)) u_shadow (
    .clk     (VCLKx8),
    .rst     (RESET),
    .a_en    (CPCS),
    .a_we    (CPWR),
    .a_addr  (CPAD),
    .a_wdata (CPDI),
    .a_rdata (CPDO),
    .b_en    (copy_rd),
    .b_addr  (cnt_q),
    .b_rdata (copy_data)
  );

  gyruss_dpram #(.AW(AW), .DW(8)) u_active (
    .clk     (VCLKx8),
    .rst     (RESET),
    .a_en    (act_we),
    .a_we    (1'b1),
    .a_addr  (wadr_q),
    .a_wdata (copy_data),
    .a_rdata (act_rd_unused),
    .b_en    (1'b1),
    .b_addr  (SPAA),
    .b_rdata (SPAD)
  );

  assign CPBSY = (state_q != IDLE);
  assign DIRTY = dirty_q;

endmodule

// File: tb/tb_gyruss_sprite_ram.sv
// Directed self-checking bench for gyruss_sprite_ram: CPU access, vblank copy,
// copy-time writes, ignored edges and reset in the middle of a copy.
module tb_gyruss_sprite_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblk;
  logic [7:0] cpad;
  logic [7:0] cpdi;
  logic       cpcs;
  logic       cpwr;
  logic [7:0] cpdo;
  logic [7:0] spaa;
  logic [7:0] spad;
  logic       cpbsy;
  logic       dirty;

  int checks = 0;
  int errors = 0;

  int   pulses   = 0;
  int   run_len  = 0;
  int   last_len = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  gyruss_sprite_ram #(.AW(8)) dut (
    .VCLKx8 (clk),
    .RESET  (rst),
    .VBLK   (vblk),
    .CPAD   (cpad),
    .CPDI   (cpdi),
    .CPCS   (cpcs),
    .CPWR   (cpwr),
    .CPDO   (cpdo),
    .SPAA   (spaa),
    .SPAD   (spad),
    .CPBSY  (cpbsy),
    .DIRTY  (dirty)
  );

  // Measures CPBSY pulses: how many, and the length of the last one in cycles.
  always @(negedge clk) begin
    if (cpbsy) begin
      if (!busy_prev) begin
        pulses  = pulses + 1;
        run_len = 1;
      end else begin
        run_len = run_len + 1;
      end
    end else if (busy_prev) begin
      last_len = run_len;
    end
    busy_prev = cpbsy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpcs = 1'b1; cpwr = 1'b1; cpad = a; cpdi = d;
    step();
    cpcs = 1'b0; cpwr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [7:0] d);
    cpcs = 1'b1; cpwr = 1'b0; cpad = a;
    step();
    d = cpdo;
    cpcs = 1'b0;
  endtask

  task automatic rd_active(input logic [7:0] a, output logic [7:0] d);
    spaa = a;
    step();
    d = spad;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cpbsy && n < 600) begin
      step();
      n++;
    end
    check("copy_terminates", cpbsy, 1'b0);
    step();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;
    int p0;

    rst = 1'b1; vblk = 1'b0; cpcs = 1'b0; cpwr = 1'b0;
    cpad = '0; cpdi = '0; spaa = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("boot_busy", cpbsy, 1'b0);

    // Baseline: active[i] = ~i, so later "old" values are known.
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), ~8'(i));
    vblk = 1'b1; step(); vblk = 1'b0;
    wait_idle();
    cpu_rd(8'h01, d);
    check("base_cpdo", d, 8'hFE);
    rd_active(8'h01, d);
    check("base_spad", d, 8'hFE);

    // Reset values; RAM contents survive.
    rst = 1'b1;
    step();
    check("rst_cpdo", cpdo, 8'h00);
    check("rst_spad", spad, 8'h00);
    check("rst_cpbsy", cpbsy, 1'b0);
    check("rst_dirty", dirty, 1'b0);
    rst = 1'b0;
    step();

    // Single CPU write: shadow only, DIRTY set, CPDO latency and hold.
    cpu_wr(8'h10, 8'hA5);
    check("t1_dirty", dirty, 1'b1);
    rd_active(8'h10, d);
    check("t1_spad_old", d, 8'hEF);
    cpu_rd(8'h10, d);
    check("t1_cpdo", d, 8'hA5);
    cpad = 8'h20;
    step();
    check("t1_cpdo_hold", cpdo, 8'hA5);

    // Full copy of i^0x5A; VBLK falls one cycle into the copy.
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'(i) ^ 8'h5A);
    p0 = pulses;
    vblk = 1'b1; step(); vblk = 1'b0;
    check("t2_busy_start", cpbsy, 1'b1);
    check("t2_dirty_clr", dirty, 1'b0);
    wait_idle();
    check("t2_pulses", pulses - p0, 1);
    check("t2_len", last_len, 257);
    for (int i = 0; i < 256; i++) begin
      rd_active(8'(i), d);
      check($sformatf("t2_active_%02h", i), d, 8'(i) ^ 8'h5A);
    end

    // Vblank with DIRTY=0 starts nothing.
    p0 = pulses;
    vblk = 1'b1; step();
    check("t3_no_busy0", cpbsy, 1'b0);
    step(); step();
    check("t3_no_busy2", cpbsy, 1'b0);
    vblk = 1'b0; step();
    check("t3_pulses", pulses - p0, 0);
    rd_active(8'h33, d);
    check("t3_active_33", d, 8'h69);
    rd_active(8'hF0, d);
    check("t3_active_f0", d, 8'hAA);

    // Writes during a copy: 0x02 already copied, 0xF0 not yet.
    cpu_wr(8'h80, 8'hDA);
    vblk = 1'b1; step(); vblk = 1'b0;   // copy cycle 0
    repeat (9) step();                   // copy cycle 9
    cpu_wr(8'h02, 8'h11);
    cpu_wr(8'hF0, 8'h22);
    wait_idle();
    check("t4_dirty", dirty, 1'b1);
    check("t4_len", last_len, 257);
    rd_active(8'hF0, d);
    check("t4_active_f0", d, 8'h22);
    rd_active(8'h02, d);
    check("t4_active_02_old", d, 8'h58);

    // Next pass picks up 0x02; a write to the address being read this cycle
    // (copy cycle 4) lands in shadow but the copy takes the old byte.
    vblk = 1'b1; step(); vblk = 1'b0;   // copy cycle 0
    repeat (4) step();                   // copy cycle 4
    cpu_wr(8'h04, 8'h77);
    wait_idle();
    check("t4b_dirty", dirty, 1'b1);
    rd_active(8'h02, d);
    check("t4b_active_02", d, 8'h11);
    rd_active(8'h04, d);
    check("t4b_active_04_old", d, 8'h5E);
    cpu_rd(8'h04, d);
    check("t4b_shadow_04", d, 8'h77);

    // Second VBLK rise during a copy is ignored and does not clear DIRTY.
    p0 = pulses;
    vblk = 1'b1; step();
    check("t6_dirty_clr", dirty, 1'b0);
    repeat (20) step();
    vblk = 1'b0; step();
    cpu_wr(8'h00, 8'h5A);
    vblk = 1'b1; step();
    check("t6_busy", cpbsy, 1'b1);
    check("t6_dirty_kept", dirty, 1'b1);
    wait_idle();
    check("t6_pulses", pulses - p0, 1);
    check("t6_len", last_len, 257);
    check("t6_dirty_end", dirty, 1'b1);
    step();
    check("t6_no_restart", cpbsy, 1'b0);
    vblk = 1'b0; step();

    // Reset at copy cycle 100: active[0..98] new, the rest keep old data.
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'(i) ^ 8'hC3);
    vblk = 1'b1; step(); vblk = 1'b0;   // copy cycle 0
    repeat (100) step();                 // copy cycle 100
    rst = 1'b1;
    step();
    check("t5_cpbsy", cpbsy, 1'b0);
    check("t5_dirty", dirty, 1'b0);
    check("t5_cpdo", cpdo, 8'h00);
    check("t5_spad", spad, 8'h00);
    rst = 1'b0;
    step();
    for (int i = 0; i < 256; i++) begin
      if (i < 99)       e = 8'(i) ^ 8'hC3;
      else if (i == 240) e = 8'h22;
      else              e = 8'(i) ^ 8'h5A;
      rd_active(8'(i), d);
      check($sformatf("t5_active_%02h", i), d, e);
    end
    check("t5_idle_after", cpbsy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gyruss_sprite_ram.md
# gyruss_sprite_ram

Sprite attribute RAM for the Gyruss video path and the responder on the renderer's attribute-fetch interface. The renderer issues an address on SPAA and receives the byte on SPAD. The CPU writes a shadow bank at any time. On each VBLANK rising edge, a copy engine transfers the shadow bank into the active bank the renderer reads, so a frame never shows a half-updated sprite table.

## Interface
Parameters:
- AW, 8, attribute address width (2^AW bytes per bank; Gyruss = 64 sprites x 4 bytes)

Ports:
- VCLKx8  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high reset
- VBLK  in  1  vertical blank level, synchronous to VCLKx8
- CPAD  in  AW  CPU byte address into shadow bank
- CPDI  in  8  CPU write data
- CPCS  in  1  CPU chip select
- CPWR  in  1  CPU write strobe, qualified by CPCS
- CPDO  out  8  CPU read data from shadow bank, registered
- SPAA  in  AW  renderer attribute address ({sprite_no, offset})
- SPAD  out  8  renderer attribute data from active bank, registered
- CPBSY  out  1  copy engine running
- DIRTY  out  1  shadow modified since last copy start

## Operation
- Two banks of 2^AW x 8:
  - Shadow bank: CPU read/write port, plus a read port for the copy engine.
  - Active bank: a write port for the copy engine, plus a read port for the renderer.
- CPU access when CPCS=1:
  - CPWR=1 writes CPDI to shadow[CPAD] and sets DIRTY.
  - CPWR=0 reads: CPDO <= shadow[CPAD].
  - When CPCS=0, CPDO holds its value.
- CPU read of an address being written in the same cycle returns the old data.
- Renderer port: SPAD <= active[SPAA] every cycle, unconditionally. A renderer read of an address the copy engine writes in the same cycle returns the old data.
- Edge detect: register VBLK_d. A rising edge is VBLK & ~VBLK_d.
- FSM states:
  - IDLE: on a rising edge with DIRTY=1, clear DIRTY, set CNT=0, go to COPY. With DIRTY=0, stay in IDLE.
  - COPY: each cycle, read shadow[CNT], CNT+1. When CNT reaches 2^AW-1, go to DRAIN.
  - DRAIN: perform the final write, then return to IDLE.
- Write pipeline: the address and data read in cycle k are written to active[k] in cycle k+1 (one-stage pipe: WADR, WEN).
- CNT is AW bits and terminates without wrapping. The terminal count is detected, not taken from an overflow bit.
- CPBSY = 1 in COPY and DRAIN.
- Boundary cases:
  - CPU write during COPY: the write lands in shadow and sets DIRTY. If its address is already copied, it appears after the next vblank copy. If not yet copied, it is copied this pass.
  - CPU write to the address being read by the copy engine in the same cycle: the copy takes the old data, and DIRTY is set.
  - VBLK rising edge during COPY or DRAIN: ignored. DIRTY is not cleared.
  - A DIRTY set and a copy start in the same cycle: DIRTY ends at 1 (set wins).
  - VBLK falling during a copy: the copy continues to completion.
  - RESET mid-copy: state goes to IDLE, the pipe write is suppressed, and the partial copy stays in the active bank. RAM contents are never cleared by reset.

## Timing
- Reset values:
  - CPDO=0, SPAD=0, CPBSY=0, DIRTY=0.
  - FSM=IDLE, CNT=0, VBLK_d=0, WEN=0.
- SPAD latency: one cycle from SPAA.
- CPDO latency: one cycle from CPAD with CPCS=1, CPWR=0.
- Copy start:
  - The FSM enters COPY on the edge after the cycle in which the VBLK rise is sampled.
  - CPBSY rises on that same edge.
  - The first active write occurs one cycle later.
- Copy length: 2^AW cycles in COPY plus 1 in DRAIN. CPBSY is high for 2^AW+1 = 257 cycles at AW=8.
- Last write: active[2^AW-1] is written in the DRAIN cycle. A renderer read issued the cycle after DRAIN sees the new value.

## Structure
- Package gyruss_sprite_ram_pkg holds:
  - the state enum {IDLE, COPY, DRAIN};
  - the default AW;
  - the Gyruss byte-offset constants (OFS_Y=3, OFS_ATTR=2, OFS_CODE=1, OFS_X=0).
- One sub-module, gyruss_dpram, instantiated twice: a generic simple dual-port RAM with a registered read and a write port, parameterised on AW and width 8. For the shadow bank, the CPU port is read/write and the copy port is read-only.

## Test plan
- Reset, then write shadow[0x10]=0xA5. Check: DIRTY=1, SPAD at SPAA=0x10 still the old value, CPDO reads 0xA5 one cycle after a read.
- Fill shadow with the pattern i^0x5A and raise VBLK. Check: CPBSY high for exactly 257 cycles, DIRTY cleared at start, and afterwards active[i]=i^0x5A for all 256 addresses.
- Raise VBLK with DIRTY=0. Check: no copy (CPBSY stays 0) and active is unchanged.
- During a copy, write shadow[0x02]=0x11 after it is copied and shadow[0xF0]=0x22 before. Check: active[0xF0]=0x22, active[0x02] is the old value, DIRTY=1. After the next vblank, active[0x02]=0x11.
- Assert RESET at copy cycle 100. Check: CPBSY=0 next cycle; active[0..98] new, active[≥99] old; outputs at reset values.
- Issue a second VBLK rising edge during a copy. Check: it is ignored, with exactly one 257-cycle CPBSY pulse.
